fp_widen: RTL
=============

FP_WIDEN -- requirements
Module: fp_widen

Interface
REQ-001 SHALL have parameter SRC_EXP_W, default 8, source exponent width.
REQ-002 SHALL have parameter SRC_MAN_W, default 23, source fraction width.
REQ-003 SHALL have parameter DST_EXP_W, default 11, destination exponent width; must exceed SRC_EXP_W.
REQ-004 SHALL have parameter DST_MAN_W, default 52, destination fraction width; must be >= SRC_MAN_W.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  source operand valid.
REQ-008 SHALL have port in_ready  output  1  block can accept an operand.
REQ-009 SHALL have port in_data  input  1+SRC_EXP_W+SRC_MAN_W  {sign, exp, fraction}.
REQ-010 SHALL have port in_ftz  input  1  flush subnormal input to signed zero; sampled with in_data.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_data  output  1+DST_EXP_W+DST_MAN_W  {sign, exp, fraction}.
REQ-014 SHALL have port out_invalid  output  1  input was signalling NaN.
REQ-015 SHALL have port out_denorm  output  1  input was subnormal (normalised or flushed).

Function
REQ-016 SHALL implement FSM IDLE -> CLASSIFY -> (NORM ->) OUT -> IDLE.
REQ-017 SHALL assert in_ready only in IDLE; transfer on in_valid && in_ready captures in_data, in_ftz; next state CLASSIFY.
REQ-018 CLASSIFY SHALL last one cycle: subnormal with in_ftz=0 -> NORM; all other classes -> OUT with result registered.
REQ-019 Normal: sign copied; exp = src_exp - SRC_BIAS + DST_BIAS (BIAS = 2^(W-1)-1); fraction left-aligned, low DST_MAN_W-SRC_MAN_W bits zero.
REQ-020 Zero: signed zero (sign preserved); out_denorm=0.
REQ-021 Infinity: exp all ones, fraction zero, sign preserved.
REQ-022 qNaN (exp all ones, fraction MSB 1): payload left-aligned, zero-filled, out_invalid=0.
REQ-023 sNaN (exp all ones, fraction nonzero, MSB 0): fraction MSB forced 1, remaining payload left-aligned, out_invalid=1.
REQ-024 Subnormal, in_ftz=1: signed zero, out_denorm=1, no NORM cycles.
REQ-025 NORM SHALL shift mantissa left one bit per cycle, incrementing shift count k, until hidden-bit position SRC_MAN_W is 1, then go to OUT.
REQ-026 Normalised exp SHALL be 1 - SRC_BIAS - k + DST_BIAS; fraction = shifted mantissa without hidden bit, left-aligned; out_denorm=1.
REQ-027 Latency from input transfer to out_valid SHALL be 2 cycles, or 2+k cycles for normalised subnormals.
REQ-028 OUT SHALL hold out_valid=1 and out_data/flags stable until out_ready=1; that cycle transitions to IDLE.
REQ-029 out_valid SHALL be 0 in all states other than OUT.
REQ-030 Minimum issue interval SHALL be 3 cycles (no accept while busy).

Reset
REQ-031 reset=0 at a clock edge SHALL force state IDLE, out_valid=0, out_data=0, out_invalid=0, out_denorm=0, k=0.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-033 Reset in any state, including mid-NORM or OUT under backpressure, SHALL discard the operation with no output.

Structure
REQ-034 Package fp_pkg SHALL hold the class enum (ZERO, SUBNORM, NORMAL, INF, QNAN, SNAN), state enum, and bias function.
REQ-035 Classification SHALL be a combinational sub-module fp_classify, parametrised on SRC_EXP_W/SRC_MAN_W.
REQ-036 Elaboration SHALL fail if DST_EXP_W <= SRC_EXP_W or DST_MAN_W < SRC_MAN_W.

Verification (default parameters)
REQ-037 0x3F800000, out_ready=1 -> out_data 0x3FF0000000000000 two cycles after transfer, flags 0.
REQ-038 0x7FA00001 -> 0x7FFC000020000000, out_invalid=1.
REQ-039 0x00000001, in_ftz=0 -> 0x36A0000000000000 after 25 cycles, out_denorm=1; with in_ftz=1, 0x80000001 -> 0x8000000000000000 after 2 cycles, out_denorm=1.
REQ-040 0xFF800000 with out_ready=0 for 5 cycles -> 0xFFF0000000000000 held stable, in_ready=0 throughout, IDLE the cycle after out_ready=1.
REQ-041 reset=0 during NORM of 0x00000001 -> out_valid=0 and in_ready=1 the cycle after reset deasserts; no output emitted.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types for the FP widening converter: operand classes, FSM states and
// the IEEE exponent bias helper.
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        SUBNORM,
        NORMAL,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    typedef enum logic [1:0] {
        IDLE,
        CLASSIFY,
        NORM,
        OUT
    } state_e;

    function automatic int bias(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier for a {exp, fraction} pair.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0] exp_i,
    input  logic [MAN_W-1:0] frac_i,
    output fp_class_e        cls_o
);

    always_comb begin
        cls_o = NORMAL;
        if (exp_i == '0) begin
            cls_o = (frac_i == '0) ? ZERO : SUBNORM;
        end else if (&exp_i) begin
            if (frac_i == '0)
                cls_o = INF;
            else
                cls_o = frac_i[MAN_W-1] ? QNAN : SNAN;
        end
    end

endmodule

// File: rtl/fp_widen.sv
// Multi-cycle float widening converter; subnormal sources are normalised one
// bit per cycle before the result is presented on a valid/ready output.
module fp_widen
    import fp_pkg::*;
#(
    parameter int SRC_EXP_W = 8,
    parameter int SRC_MAN_W = 23,
    parameter int DST_EXP_W = 11,
    parameter int DST_MAN_W = 52
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SRC_EXP_W+SRC_MAN_W:0]     in_data,
    input  logic                             in_ftz,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DST_EXP_W+DST_MAN_W:0]     out_data,
    output logic                             out_invalid,
    output logic                             out_denorm
);

    localparam int SRC_BIAS = bias(SRC_EXP_W);
    localparam int DST_BIAS = bias(DST_EXP_W);
    localparam int PAD      = DST_MAN_W - SRC_MAN_W;
    localparam int K_W      = $clog2(SRC_MAN_W + 1);
    localparam int OUT_W    = 1 + DST_EXP_W + DST_MAN_W;

    generate
        if (DST_EXP_W <= SRC_EXP_W || DST_MAN_W < SRC_MAN_W) begin : g_bad_params
            $error("fp_widen: destination format must be wider than source");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic [SRC_EXP_W-1:0]    exp_q, exp_d;
    logic [SRC_MAN_W:0]      mant_q, mant_d;
    logic                    ftz_q, ftz_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    out_invalid_q, out_invalid_d;
    logic                    out_denorm_q, out_denorm_d;

    fp_class_e               cls;
    logic [SRC_MAN_W:0]      mant_shift;
    logic [K_W-1:0]          k_inc;
    logic [DST_EXP_W-1:0]    exp_normal;
    logic [DST_EXP_W-1:0]    exp_subn;
    logic [SRC_MAN_W-1:0]    frac;

    fp_classify #(
        .EXP_W (SRC_EXP_W),
        .MAN_W (SRC_MAN_W)
    ) u_classify (
        .exp_i  (exp_q),
        .frac_i (mant_q[SRC_MAN_W-1:0]),
        .cls_o  (cls)
    );

    function automatic logic [DST_MAN_W-1:0] align(input logic [SRC_MAN_W-1:0] f);
        return DST_MAN_W'(f) << PAD;
    endfunction

    assign frac       = mant_q[SRC_MAN_W-1:0];
    assign mant_shift = mant_q << 1;
    assign k_inc      = k_q + 1'b1;
    assign exp_normal = DST_EXP_W'(int'(exp_q) - SRC_BIAS + DST_BIAS);
    // k_inc is the shift count including the shift being taken this cycle.
    assign exp_subn   = DST_EXP_W'(1 - SRC_BIAS - int'(k_inc) + DST_BIAS);

    always_comb begin
        state_d       = state_q;
        sign_d        = sign_q;
        exp_d         = exp_q;
        mant_d        = mant_q;
        ftz_d         = ftz_q;
        k_d           = k_q;
        out_data_d    = out_data_q;
        out_invalid_d = out_invalid_q;
        out_denorm_d  = out_denorm_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[SRC_EXP_W+SRC_MAN_W];
                    exp_d   = in_data[SRC_EXP_W+SRC_MAN_W-1:SRC_MAN_W];
                    mant_d  = {1'b0, in_data[SRC_MAN_W-1:0]};
                    ftz_d   = in_ftz;
                    k_d     = '0;
                    state_d = CLASSIFY;
                end
            end
            CLASSIFY: begin
                out_invalid_d = 1'b0;
                out_denorm_d  = 1'b0;
                state_d       = OUT;
                unique case (cls)
                    ZERO:    out_data_d = {sign_q, {(OUT_W-1){1'b0}}};
                    SUBNORM: begin
                        if (ftz_q) begin
                            out_data_d   = {sign_q, {(OUT_W-1){1'b0}}};
                            out_denorm_d = 1'b1;
                        end else begin
                            state_d = NORM;
                        end
                    end
                    NORMAL:  out_data_d = {sign_q, exp_normal, align(frac)};
                    INF:     out_data_d = {sign_q, {DST_EXP_W{1'b1}}, {DST_MAN_W{1'b0}}};
                    QNAN:    out_data_d = {sign_q, {DST_EXP_W{1'b1}}, align(frac)};
                    SNAN: begin
                        out_data_d    = {sign_q, {DST_EXP_W{1'b1}},
                                         align(frac | {1'b1, {(SRC_MAN_W-1){1'b0}}})};
                        out_invalid_d = 1'b1;
                    end
                    default: out_data_d = '0;
                endcase
            end
            NORM: begin
                mant_d = mant_shift;
                k_d    = k_inc;
                if (mant_shift[SRC_MAN_W]) begin
                    out_data_d   = {sign_q, exp_subn, align(mant_shift[SRC_MAN_W-1:0])};
                    out_denorm_d = 1'b1;
                    state_d      = OUT;
                end
            end
            OUT: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            sign_q        <= 1'b0;
            exp_q         <= '0;
            mant_q        <= '0;
            ftz_q         <= 1'b0;
            k_q           <= '0;
            out_data_q    <= '0;
            out_invalid_q <= 1'b0;
            out_denorm_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sign_q        <= sign_d;
            exp_q         <= exp_d;
            mant_q        <= mant_d;
            ftz_q         <= ftz_d;
            k_q           <= k_d;
            out_data_q    <= out_data_d;
            out_invalid_q <= out_invalid_d;
            out_denorm_q  <= out_denorm_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == OUT);
    assign out_data    = out_data_q;
    assign out_invalid = out_invalid_q;
    assign out_denorm  = out_denorm_q;

endmodule
